// File: rtl/framebuffer_ring.sv
// N-buffer framebuffer ring: two scanout read ports, two renderer write ports, built-in clear engine.
// Optional FB_STATS_EN adds saturating swap/repeat/overrun counters.
module framebuffer_ring #(
    parameter int               NUM_BUFS    = 2,
    parameter int               PIX_W       = 4,
    parameter int               FB_DEPTH    = 19200,
    parameter int               ADDR_W      = $clog2(FB_DEPTH),
    parameter int               SWAP_DIV    = 2,
    parameter int               CLEAR_SPLIT = FB_DEPTH / 4,
    parameter logic [PIX_W-1:0] CLEAR_TOP   = 4'b0101,
    parameter logic [PIX_W-1:0] CLEAR_BOT   = 4'b1011
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              vsync,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [PIX_W-1:0]  vga_data,
    input  logic [ADDR_W-1:0] lcd_addr,
    output logic [PIX_W-1:0]  lcd_data,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [PIX_W-1:0]  wr1_data,
    input  logic              wr1_en,
    input  logic [ADDR_W-1:0] wr2_addr,
    input  logic [PIX_W-1:0]  wr2_data,
    input  logic              wr2_en,
    input  logic              frame_done,
    output logic              back_ready,
    output logic              clearing,
    output logic [1:0]        disp_idx,
    output logic [1:0]        pend_cnt,
    output logic              repeat_frame,
    output logic              overrun
`ifdef FB_STATS_EN
    ,
    output logic [15:0]       swap_cnt,
    output logic [15:0]       repeat_cnt,
    output logic [15:0]       overrun_cnt
`endif
);

    localparam int MEM_AW = $clog2(NUM_BUFS * FB_DEPTH);
    localparam int DIV_W  = $clog2(SWAP_DIV + 1);
    localparam int CNT_W  = ADDR_W + 1;
    localparam logic [1:0]       LAST_PEND = 2'(NUM_BUFS - 1);
    localparam logic [2:0]       NB3       = 3'(NUM_BUFS);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FB_DEPTH);
    localparam logic [CNT_W-1:0] SPLIT_C   = CNT_W'(CLEAR_SPLIT);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SWAP_DIV - 1);

    // All buffers share one flat array; buffer b occupies [b*FB_DEPTH, (b+1)*FB_DEPTH).
    logic [PIX_W-1:0] mem [NUM_BUFS*FB_DEPTH];

    logic             vsync_q;
    logic [DIV_W-1:0] div_cnt;
    logic [CNT_W-1:0] clr_c;

    logic       fall, swap_opp, swap_adv, fd_ok, exists_n, start_clr;
    logic       accept, clr_last, c1_ok;
    logic [1:0] draw_idx, disp_n, pend_n, draw_n;

    function automatic logic [1:0] ring_wrap(input logic [2:0] v);
        logic [2:0] r;
        r = (v >= NB3) ? v - NB3 : v;
        return r[1:0];
    endfunction

    function automatic logic [MEM_AW-1:0] mem_idx(input logic [1:0] b, input logic [CNT_W-1:0] a);
        return MEM_AW'(b) * MEM_AW'(FB_DEPTH) + MEM_AW'(a);
    endfunction

    function automatic logic [PIX_W-1:0] clr_colour(input logic [CNT_W-1:0] a);
        return (a < SPLIT_C) ? CLEAR_TOP : CLEAR_BOT;
    endfunction

    always_comb begin
        fall      = vsync_q & ~vsync;
        swap_opp  = fall && (div_cnt == DIV_LAST);
        swap_adv  = swap_opp && (pend_cnt != 2'd0);
        fd_ok     = frame_done && back_ready;
        draw_idx  = ring_wrap(3'(disp_idx) + 3'd1 + 3'(pend_cnt));
        disp_n    = swap_adv ? ring_wrap(3'(disp_idx) + 3'd1) : disp_idx;
        pend_n    = pend_cnt + 2'(fd_ok) - 2'(swap_adv);
        draw_n    = ring_wrap(3'(disp_n) + 3'd1 + 3'(pend_n));
        exists_n  = pend_n < LAST_PEND;
        // A fresh draw buffer appears either after a completed frame or when a stall is released.
        start_clr = exists_n && (fd_ok || (swap_adv && (pend_cnt == LAST_PEND)));
        accept    = back_ready && !clearing;
        clr_last  = (clr_c + CNT_W'(2)) >= DEPTH_C;
        c1_ok     = (clr_c + CNT_W'(1)) < DEPTH_C;
    end

    always_ff @(posedge clock) begin
        vsync_q <= vsync;
        if (reset) begin
            disp_idx     <= 2'd0;
            pend_cnt     <= 2'd0;
            div_cnt      <= '0;
            back_ready   <= 1'b0;
            clearing     <= 1'b1;
            clr_c        <= '0;
            repeat_frame <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            repeat_frame <= swap_opp && (pend_cnt == 2'd0);
            overrun      <= frame_done && !back_ready;
            if (fall)
                div_cnt <= swap_opp ? '0 : div_cnt + DIV_W'(1);
            disp_idx <= disp_n;
            pend_cnt <= pend_n;
            if (start_clr) begin
                clearing   <= 1'b1;
                clr_c      <= '0;
                back_ready <= 1'b0;
            end else if (clearing) begin
                if (clr_last) begin
                    clearing   <= 1'b0;
                    back_ready <= 1'b1;
                end else begin
                    clr_c <= clr_c + CNT_W'(2);
                end
            end else if (!exists_n) begin
                back_ready <= 1'b0;
            end
        end
    end

    // Reads always come from the display buffer and writes from the draw buffer, so they never collide.
    always_ff @(posedge clock) begin
        if (reset) begin
            vga_data <= '0;
            lcd_data <= '0;
        end else begin
            vga_data <= mem[mem_idx(disp_idx, {1'b0, vga_addr})];
            lcd_data <= mem[mem_idx(disp_idx, {1'b0, lcd_addr})];
        end
        if (!reset && clearing) begin
            mem[mem_idx(draw_idx, clr_c)] <= clr_colour(clr_c);
            if (c1_ok)
                mem[mem_idx(draw_idx, clr_c + CNT_W'(1))] <= clr_colour(clr_c + CNT_W'(1));
        end else if (!reset && accept) begin
            if (wr1_en && ({1'b0, wr1_addr} < DEPTH_C))
                mem[mem_idx(draw_idx, {1'b0, wr1_addr})] <= wr1_data;
            if (wr2_en && ({1'b0, wr2_addr} < DEPTH_C))
                mem[mem_idx(draw_idx, {1'b0, wr2_addr})] <= wr2_data;
        end
    end

`ifdef FB_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            swap_cnt    <= 16'd0;
            repeat_cnt  <= 16'd0;
            overrun_cnt <= 16'd0;
        end else begin
            if (swap_adv && (swap_cnt != 16'hFFFF))
                swap_cnt <= swap_cnt + 16'd1;
            if (swap_opp && (pend_cnt == 2'd0) && (repeat_cnt != 16'hFFFF))
                repeat_cnt <= repeat_cnt + 16'd1;
            if (frame_done && !back_ready && (overrun_cnt != 16'hFFFF))
                overrun_cnt <= overrun_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_framebuffer_ring.sv
// Bench for framebuffer_ring: instance A (N=2, depth 16) and B (N=3, depth 15) share one stimulus.
// A frame-level model predicts every output each cycle; directed literals pin key moments.
module tb_framebuffer_ring;

    localparam int SWAP_DIV = 2;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset, vsync, frame_done, wr1_en, wr2_en;
    logic [3:0] vga_addr, lcd_addr, wr1_addr, wr2_addr, wr1_data, wr2_data;

    logic [3:0] a_vga, a_lcd, b_vga, b_lcd;
    logic [1:0] a_disp, a_pend, b_disp, b_pend;
    logic       a_br, a_clr, a_rep, a_ovr, b_br, b_clr, b_rep, b_ovr;

    framebuffer_ring #(.NUM_BUFS(2), .PIX_W(4), .FB_DEPTH(16), .SWAP_DIV(SWAP_DIV), .CLEAR_SPLIT(4)) dut_a (
        .clock(clock), .reset(reset), .vsync(vsync),
        .vga_addr(vga_addr), .vga_data(a_vga), .lcd_addr(lcd_addr), .lcd_data(a_lcd),
        .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_en(wr1_en),
        .wr2_addr(wr2_addr), .wr2_data(wr2_data), .wr2_en(wr2_en),
        .frame_done(frame_done), .back_ready(a_br), .clearing(a_clr),
        .disp_idx(a_disp), .pend_cnt(a_pend), .repeat_frame(a_rep), .overrun(a_ovr));

    framebuffer_ring #(.NUM_BUFS(3), .PIX_W(4), .FB_DEPTH(15), .SWAP_DIV(SWAP_DIV), .CLEAR_SPLIT(3)) dut_b (
        .clock(clock), .reset(reset), .vsync(vsync),
        .vga_addr(vga_addr), .vga_data(b_vga), .lcd_addr(lcd_addr), .lcd_data(b_lcd),
        .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_en(wr1_en),
        .wr2_addr(wr2_addr), .wr2_data(wr2_data), .wr2_en(wr2_en),
        .frame_done(frame_done), .back_ready(b_br), .clearing(b_clr),
        .disp_idx(b_disp), .pend_cnt(b_pend), .repeat_frame(b_rep), .overrun(b_ovr));

    int errors = 0;
    int checks = 0;
    int rep_a = 0;
    int rep_b = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- frame-level model ----------------
    int m_n[2]     = '{2, 3};
    int m_d[2]     = '{16, 15};
    int m_split[2] = '{4, 3};
    int m_disp[2], m_pend[2], m_div[2], m_br[2], m_clr[2], m_left[2], m_cbuf[2];
    int m_rep[2], m_ovr[2], m_vga[2], m_lcd[2];
    int m_mem[2][4][16];
    bit m_vq = 1'b0;
    bit started = 1'b0;

    task automatic model_step(input int k, input bit fall);
        int n, d, draw_old, draw_new, br0;
        bit opp, adv, fd, ex_old, ex_new;
        n = m_n[k];
        d = m_d[k];
        if (reset) begin
            m_disp[k] = 0; m_pend[k] = 0; m_div[k] = 0; m_br[k] = 0;
            m_clr[k] = 1; m_left[k] = (d + 1) / 2; m_cbuf[k] = 1;
            m_rep[k] = 0; m_ovr[k] = 0; m_vga[k] = 0; m_lcd[k] = 0;
            for (int b = 0; b < 4; b++)
                for (int a = 0; a < 16; a++)
                    m_mem[k][b][a] = -1;
            return;
        end
        m_vga[k] = (int'(vga_addr) < d) ? m_mem[k][m_disp[k]][vga_addr] : -1;
        m_lcd[k] = (int'(lcd_addr) < d) ? m_mem[k][m_disp[k]][lcd_addr] : -1;
        br0      = m_br[k];
        ex_old   = m_pend[k] < n - 1;
        draw_old = (m_disp[k] + 1 + m_pend[k]) % n;
        if (br0 != 0) begin
            if (wr1_en && int'(wr1_addr) < d) m_mem[k][draw_old][wr1_addr] = int'(wr1_data);
            if (wr2_en && int'(wr2_addr) < d) m_mem[k][draw_old][wr2_addr] = int'(wr2_data);
        end
        if (m_clr[k] != 0) begin
            m_left[k]--;
            if (m_left[k] == 0) begin
                m_clr[k] = 0;
                m_br[k]  = 1;
                for (int a = 0; a < d; a++)
                    m_mem[k][m_cbuf[k]][a] = (a < m_split[k]) ? 5 : 11;
            end
        end
        opp = 1'b0;
        if (fall) begin
            m_div[k]++;
            if (m_div[k] == SWAP_DIV) begin
                m_div[k] = 0;
                opp = 1'b1;
            end
        end
        fd       = frame_done && (br0 != 0);
        m_ovr[k] = (frame_done && br0 == 0) ? 1 : 0;
        adv      = opp && m_pend[k] > 0;
        m_rep[k] = (opp && m_pend[k] == 0) ? 1 : 0;
        if (adv) begin
            m_disp[k] = (m_disp[k] + 1) % n;
            m_pend[k]--;
        end
        if (fd) m_pend[k]++;
        ex_new   = m_pend[k] < n - 1;
        draw_new = (m_disp[k] + 1 + m_pend[k]) % n;
        if (ex_new && (!ex_old || draw_new != draw_old)) begin
            m_clr[k] = 1; m_br[k] = 0; m_left[k] = (d + 1) / 2; m_cbuf[k] = draw_new;
            for (int a = 0; a < 16; a++)
                m_mem[k][draw_new][a] = -1;
        end else if (!ex_new) begin
            m_br[k] = 0;
        end
    endtask

    always @(posedge clock) begin
        bit fall;
        fall = m_vq && !vsync;
        model_step(0, fall);
        model_step(1, fall);
        m_vq = vsync;
        started = 1'b1;
    end

    task automatic cmp_inst(input int k, input logic br, input logic clr, input logic [1:0] disp,
                            input logic [1:0] pend, input logic rep, input logic ovr,
                            input logic [3:0] vga, input logic [3:0] lcd);
        string p;
        p = (k == 0) ? "A" : "B";
        chk({p, ".back_ready"}, int'(br), m_br[k]);
        chk({p, ".clearing"}, int'(clr), m_clr[k]);
        chk({p, ".disp_idx"}, int'(disp), m_disp[k]);
        chk({p, ".pend_cnt"}, int'(pend), m_pend[k]);
        chk({p, ".repeat_frame"}, int'(rep), m_rep[k]);
        chk({p, ".overrun"}, int'(ovr), m_ovr[k]);
        if (m_vga[k] >= 0) chk({p, ".vga_data"}, int'(vga), m_vga[k]);
        if (m_lcd[k] >= 0) chk({p, ".lcd_data"}, int'(lcd), m_lcd[k]);
    endtask

    always @(negedge clock) begin
        if (started) begin
            cmp_inst(0, a_br, a_clr, a_disp, a_pend, a_rep, a_ovr, a_vga, a_lcd);
            cmp_inst(1, b_br, b_clr, b_disp, b_pend, b_rep, b_ovr, b_vga, b_lcd);
            if (a_rep) rep_a++;
            if (b_rep) rep_b++;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic vfall();
        vsync = 1'b1;
        cyc(2);
        vsync = 1'b0;
        cyc(1);
    endtask

    task automatic pulse_fd();
        frame_done = 1'b1;
        cyc(1);
        frame_done = 1'b0;
    endtask

    initial begin
        int ra0, rb0;
        reset = 1'b1; vsync = 1'b0; frame_done = 1'b0;
        wr1_en = 1'b0; wr2_en = 1'b0; wr1_addr = 4'd0; wr2_addr = 4'd0;
        wr1_data = 4'd0; wr2_data = 4'd0; vga_addr = 4'd0; lcd_addr = 4'd0;
        cyc(3);
        chk("reset.disp_idx", int'(a_disp), 0);
        chk("reset.pend_cnt", int'(a_pend), 0);
        chk("reset.back_ready", int'(a_br), 0);
        chk("reset.clearing", int'(a_clr), 1);
        chk("reset.vga_data", int'(a_vga), 0);
        reset = 1'b0;

        cyc(7);
        chk("clear7.clearing", int'(a_clr), 1);
        chk("clear7.back_ready", int'(a_br), 0);
        cyc(1);
        chk("clear8.back_ready_A", int'(a_br), 1);
        chk("clear8.clearing_A", int'(a_clr), 0);
        chk("clear8.back_ready_B", int'(b_br), 1);

        wr1_en = 1'b1; wr1_addr = 4'd1; wr1_data = 4'd9;
        wr2_en = 1'b1; wr2_addr = 4'd10; wr2_data = 4'd7;
        cyc(1);
        wr2_en = 1'b0; wr1_addr = 4'd2; wr1_data = 4'd10;
        cyc(1);
        wr1_addr = 4'd3; wr1_data = 4'd12;
        cyc(1);
        wr1_en = 1'b0;

        pulse_fd();
        chk("fd1.pend_A", int'(a_pend), 1);
        chk("fd1.back_ready_A", int'(a_br), 0);
        chk("fd1.clearing_B", int'(b_clr), 1);
        pulse_fd();
        chk("fd2.overrun_A", int'(a_ovr), 1);
        chk("fd2.pend_A", int'(a_pend), 1);
        cyc(8);
        chk("n3.back_ready_B", int'(b_br), 1);
        chk("n3.pend_B", int'(b_pend), 1);
        chk("n2.back_ready_A", int'(a_br), 0);

        vfall();
        vfall();
        chk("swap.disp_A", int'(a_disp), 1);
        chk("swap.pend_A", int'(a_pend), 0);
        chk("swap.clearing_A", int'(a_clr), 1);
        chk("swap.disp_B", int'(b_disp), 1);
        chk("swap.clearing_B", int'(b_clr), 0);

        vga_addr = 4'd3; cyc(1);
        chk("rd3.vga_A", int'(a_vga), 12);
        chk("rd3.vga_B", int'(b_vga), 12);
        vga_addr = 4'd4; cyc(1);
        chk("rd4.vga_A", int'(a_vga), 11);
        chk("rd4.vga_B", int'(b_vga), 11);
        vga_addr = 4'd10; lcd_addr = 4'd0; cyc(1);
        chk("rd10.vga_A", int'(a_vga), 7);
        chk("rd0.lcd_A", int'(a_lcd), 5);
        chk("rd0.lcd_B", int'(b_lcd), 5);
        vga_addr = 4'd1; cyc(1);
        chk("rd1.vga_A", int'(a_vga), 9);
        cyc(8);
        chk("reclear.back_ready_A", int'(a_br), 1);

        #1;
        ra0 = rep_a; rb0 = rep_b;
        @(negedge clock);
        repeat (4) vfall();
        #1;
        chk("repeat.count_A", rep_a - ra0, 2);
        chk("repeat.count_B", rep_b - rb0, 2);
        chk("repeat.disp_A", int'(a_disp), 1);
        chk("repeat.disp_B", int'(b_disp), 1);
        @(negedge clock);

        pulse_fd();
        cyc(9);
        chk("pre_sim.back_ready_B", int'(b_br), 1);
        vfall();
        vsync = 1'b1;
        cyc(2);
        vsync = 1'b0; frame_done = 1'b1;
        cyc(1);
        frame_done = 1'b0;
        chk("sim.disp_B", int'(b_disp), 2);
        chk("sim.pend_B", int'(b_pend), 1);
        chk("sim.clearing_B", int'(b_clr), 1);
        chk("sim.overrun_A", int'(a_ovr), 1);
        chk("sim.disp_A", int'(a_disp), 0);

        vga_addr = 4'd0;
        cyc(9);
        chk("supp.vga0_B", int'(b_vga), 5);
        chk("supp.vga0_A", int'(a_vga), 5);
        vga_addr = 4'd14;
        cyc(1);
        chk("supp.vga14_B", int'(b_vga), 11);
        cyc(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
